// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Instruction-fetch sequencer for the RV32 core. It owns the program counter,
// presents it combinationally to instruction memory, and captures each
// returned word together with its PC in a small FIFO. Decode drains the FIFO
// over a valid/ready handshake. start/halt_req control fetching, and a
// redirect loads a new PC and flushes everything that was buffered.
//
// Ports:
//   clk              core clock, all state updates on the rising edge
//   rst_n            synchronous active-low reset
//   start            begin/resume fetching (IDLE or HALTED only)
//   halt_req         stop fetching and drain the buffer (RUN only)
//   redirect_valid   load redirect_target into pc and flush the buffer
//   redirect_target  new PC; low two bits are dropped
//   imem_addr        address to instruction memory (equals pc)
//   imem_instr       combinational read data from instruction memory
//   if_valid         buffer head is valid
//   if_ready         decode accepts the head
//   if_instr         head instruction, 0 when empty
//   if_pc            PC of head instruction, 0 when empty
//   busy             high in RUN or DRAIN
//   misalign_err     sticky: a redirect target was not word-aligned
// -----------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        busy,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            misalign_q, misalign_d;
    logic            busy_q, busy_d;

    logic [31:0]     buf_instr [DEPTH];
    logic [31:0]     buf_pc    [DEPTH];

    logic            pop;
    logic            fetch_en;

    // A pop is allowed while full together with a push, so a stalled-free
    // stream sustains one word per cycle even at DEPTH entries.
    always_comb begin
        pop      = (count_q != '0) && if_ready;
        fetch_en = (state_q == RUN) && !redirect_valid && !halt_req &&
                   ((count_q < CW'(DEPTH)) || pop);
    end

    // Next-state logic. A redirect overrides pops, pushes and the normal
    // state transitions; the buffer is emptied by rewinding both pointers.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        misalign_d = misalign_q;

        if (redirect_valid) begin
            pc_d     = {redirect_target[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
            if (state_q == DRAIN) begin
                state_d = HALTED;
            end
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (fetch_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                pc_d     = pc_q + 32'd4;
            end
            case ({fetch_en, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            case (state_q)
                IDLE:    if (start)    state_d = RUN;
                RUN:     if (halt_req) state_d = DRAIN;
                DRAIN:   if (count_q == '0) state_d = HALTED;
                HALTED:  if (start)    state_d = RUN;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            busy_q     <= busy_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (fetch_en) begin
            buf_instr[wr_ptr_q] <= imem_instr;
            buf_pc[wr_ptr_q]    <= pc_q;
        end
    end

    always_comb begin
        imem_addr    = pc_q;
        if_valid     = (count_q != '0);
        if_instr     = if_valid ? buf_instr[rd_ptr_q] : 32'd0;
        if_pc        = if_valid ? buf_pc[rd_ptr_q]    : 32'd0;
        busy         = busy_q;
        misalign_err = misalign_q;
    end

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//
// Bench for fetch_controller (DEPTH=2, RESET_PC=0). A behavioural instruction
// memory answers imem_addr combinationally. A cycle table covers start-up,
// backpressure and control priority; hand-written sequences cover redirect,
// misalignment, halt/drain, redirect-in-drain and mid-run reset. Accepted
// words are compared in order against a queue of expected {pc, instr} pairs.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        busy;
    logic        misalign_err;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    word_t sb[$];
    logic  sbOn = 1'b0;
    int    popsSeen = 0;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        halt;
        logic        rdy;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic [31:0] expAddr;
        logic        expBusy;
    } vec_t;

    vec_t vecs[$];

    fetch_controller #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .halt_req        (halt_req),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .busy            (busy),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a few known words, a derived pattern elsewhere.
    function automatic logic [31:0] imemModel(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h0000_00B3;
            32'h04:  return 32'h0010_80B3;
            32'h08:  return 32'h0021_01B3;
            32'h0C:  return 32'h4021_8233;
            default: return {a[23:0], 8'h13};
        endcase
    endfunction

    always_comb imem_instr = imemModel(imem_addr);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, score any handshake that completes at the
    // coming edge, then advance to just after that edge.
    task automatic applyStimulus(input logic rstN, input logic st, input logic hlt,
                                 input logic rdy, input logic rv,
                                 input logic [31:0] rt);
        word_t e;
        rst_n           = rstN;
        start           = st;
        halt_req        = hlt;
        if_ready        = rdy;
        redirect_valid  = rv;
        redirect_target = rt;
        #1;
        if (sbOn && if_valid === 1'b1 && if_ready) begin
            popsSeen++;
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_pc", if_pc, e.pc);
                checkOutput("sb_instr", if_instr, e.instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b1, 1'b0, 1'b0, rdy, 1'b0, 32'd0);
    endtask

    task automatic expectWords(input logic [31:0] firstPc, input int n);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.pc    = firstPc + 32'(4 * i);
            w.instr = imemModel(w.pc);
            sb.push_back(w);
        end
    endtask

    // Reset, start with decode stalled, and let two words fill the buffer.
    task automatic fillFull();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        idle(1'b0);
        idle(1'b0);
    endtask

    task automatic addVec(input logic r, input logic s, input logic h, input logic y,
                          input logic v, input logic [31:0] p, input logic [31:0] ins,
                          input logic [31:0] a, input logic b);
        vec_t t;
        t.rst_n = r; t.start = s; t.halt = h; t.rdy = y;
        t.expValid = v; t.expPc = p; t.expInstr = ins; t.expAddr = a; t.expBusy = b;
        vecs.push_back(t);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'd0;

        // rst start halt rdy | valid pc instr addr busy
        addVec(0, 0, 0, 0,  0, 32'h00, 32'h0000_0000, 32'h00, 0);
        addVec(1, 1, 0, 1,  0, 32'h00, 32'h0000_0000, 32'h00, 1);
        addVec(1, 0, 0, 1,  1, 32'h00, 32'h0000_00B3, 32'h04, 1);
        addVec(1, 0, 0, 1,  1, 32'h04, 32'h0010_80B3, 32'h08, 1);
        addVec(1, 0, 0, 1,  1, 32'h08, 32'h0021_01B3, 32'h0C, 1);
        addVec(0, 0, 0, 0,  0, 32'h00, 32'h0000_0000, 32'h00, 0);
        addVec(1, 0, 1, 0,  0, 32'h00, 32'h0000_0000, 32'h00, 0);
        addVec(1, 1, 1, 0,  0, 32'h00, 32'h0000_0000, 32'h00, 1);
        addVec(1, 0, 0, 0,  1, 32'h00, 32'h0000_00B3, 32'h04, 1);
        addVec(1, 0, 0, 0,  1, 32'h00, 32'h0000_00B3, 32'h08, 1);
        addVec(1, 0, 0, 0,  1, 32'h00, 32'h0000_00B3, 32'h08, 1);
        addVec(1, 1, 0, 0,  1, 32'h00, 32'h0000_00B3, 32'h08, 1);
        addVec(1, 0, 0, 1,  1, 32'h04, 32'h0010_80B3, 32'h0C, 1);
        addVec(1, 0, 0, 1,  1, 32'h08, 32'h0021_01B3, 32'h10, 1);
        addVec(1, 0, 0, 1,  1, 32'h0C, 32'h4021_8233, 32'h14, 1);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("reset_misalign", {31'd0, misalign_err}, 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].start, vecs[i].halt, vecs[i].rdy,
                          1'b0, 32'd0);
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d_pc", i), if_pc, vecs[i].expPc);
            checkOutput($sformatf("vec%0d_instr", i), if_instr, vecs[i].expInstr);
            checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].expBusy});
        end

        $display("[TB] redirect with full buffer");
        fillFull();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0C);
        checkOutput("redir_flush_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("redir_addr", imem_addr, 32'h0C);
        checkOutput("redir_busy", {31'd0, busy}, 32'd1);
        sb.delete();
        expectWords(32'h0C, 5);
        popsSeen = 0;
        sbOn = 1'b1;
        idle(1'b1);
        checkOutput("redir_head_pc", if_pc, 32'h0C);
        checkOutput("redir_head_instr", if_instr, 32'h4021_8233);
        for (int i = 0; i < 5; i++) idle(1'b1);
        sbOn = 1'b0;
        checkOutput("redir_sb_left", sb.size(), 32'd0);
        checkOutput("redir_misalign", {31'd0, misalign_err}, 32'd0);

        $display("[TB] misaligned redirect");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11);
        checkOutput("mis_addr", imem_addr, 32'h10);
        checkOutput("mis_flag", {31'd0, misalign_err}, 32'd1);
        checkOutput("mis_valid", {31'd0, if_valid}, 32'd0);
        idle(1'b0);
        checkOutput("mis_head_pc", if_pc, 32'h10);
        checkOutput("mis_head_instr", if_instr, imemModel(32'h10));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
        for (int i = 0; i < 6; i++) idle(1'($urandom_range(0, 1)));
        checkOutput("mis_sticky", {31'd0, misalign_err}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("mis_cleared", {31'd0, misalign_err}, 32'd0);

        $display("[TB] halt and drain");
        fillFull();
        sb.delete();
        expectWords(32'h00, 2);
        sbOn = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("halt_busy", {31'd0, busy}, 32'd1);
        checkOutput("halt_addr", imem_addr, 32'h08);
        begin
            int n;
            n = 0;
            while (busy !== 1'b0 && n < 8) begin
                idle(1'b1);
                n++;
            end
            if (busy !== 1'b0) checkOutput("halt_timeout", {31'd0, busy}, 32'd0);
        end
        sbOn = 1'b0;
        checkOutput("halt_sb_left", sb.size(), 32'd0);
        checkOutput("halt_pc_hold", imem_addr, 32'h08);
        checkOutput("halt_valid", {31'd0, if_valid}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("resume_busy", {31'd0, busy}, 32'd1);
        idle(1'b0);
        checkOutput("resume_pc", if_pc, 32'h08);
        checkOutput("resume_instr", if_instr, 32'h0021_01B3);

        $display("[TB] redirect while draining");
        fillFull();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("drain_busy", {31'd0, busy}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        checkOutput("drain_redir_busy", {31'd0, busy}, 32'd0);
        checkOutput("drain_redir_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("drain_redir_addr", imem_addr, 32'h40);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        idle(1'b0);
        checkOutput("drain_resume_pc", if_pc, 32'h40);

        $display("[TB] reset mid-run");
        fillFull();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h00);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        checkOutput("rst_nofetch_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst_nofetch_addr", imem_addr, 32'h00);

        $display("[TB] random backpressure stream");
        sb.delete();
        expectWords(32'h00, 48);
        popsSeen = 0;
        sbOn = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 40; i++) idle(1'($urandom_range(0, 1)));
        sbOn = 1'b0;
        checkOutput("stream_progress", {31'd0, popsSeen > 5}, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
